// File: rtl/dds_phase_gen_pkg.sv
// Shared defaults for the DDS phase generator slice.
package dds_phase_gen_pkg;
  localparam int PHASE_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF  = 8;
  localparam int DATA_WIDTH_DEF  = 16;
  localparam int FIFO_DEPTH_DEF  = 4;
endpackage

// File: rtl/dds_sample_fifo.sv
// Show-ahead sample buffer; head is forced to zero while empty so idle outputs stay clean.
module dds_sample_fifo
  import dds_phase_gen_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = DATA_WIDTH_DEF + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_wr_ptr;
  logic [PTRW-1:0]  r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // The issuer's credit scheme must keep this from ever firing.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(i_push && w_full)) else $error("dds_sample_fifo push while full");
  end
endmodule

// File: rtl/dds_phase_gen.sv
// Phase accumulator + LUT address issue with credit flow control and a read-latency alignment pipe.
// Handshake: a sample transfers on a rising edge where sample_valid && sample_ready are both high.
module dds_phase_gen
  import dds_phase_gen_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   phase_clr,
  input  logic                   ftw_load,
  input  logic [PHASE_WIDTH-1:0] ftw_in,
  input  logic [PHASE_WIDTH-1:0] phase_off,
  output logic [ADDR_WIDTH-1:0]  r_addr,
  input  logic [DATA_WIDTH-1:0]  lut_q,
  output logic [DATA_WIDTH-1:0]  sample,
  output logic                   sample_wrap,
  output logic                   sample_valid,
  input  logic                   sample_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = CW + 1;

  logic [PHASE_WIDTH-1:0] r_acc;
  logic [PHASE_WIDTH-1:0] r_ftw;
  logic                   r_carry;
  logic                   r_v1;
  logic                   r_wrap1;
  logic                   r_v2;
  logic                   r_wrap2;

  logic [CW-1:0]          w_count;
  logic                   w_fifo_empty;
  logic [IW-1:0]          w_inflight;
  logic                   w_issue;
  logic [PHASE_WIDTH-1:0] w_acc_base;
  logic [PHASE_WIDTH-1:0] w_addr_phase;
  logic [PHASE_WIDTH:0]   w_acc_sum;
  logic [DATA_WIDTH:0]    w_head;

  // Every read still in the pipe owns a buffer slot; a same-cycle pop is not credited.
  assign w_inflight   = IW'(w_count) + IW'(r_v1) + IW'(r_v2);
  assign w_issue      = en && (w_inflight < IW'(FIFO_DEPTH));
  assign w_acc_base   = phase_clr ? '0 : r_acc;
  assign w_addr_phase = w_acc_base + phase_off;
  assign w_acc_sum    = {1'b0, w_acc_base} + {1'b0, r_ftw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_ftw   <= '0;
      r_carry <= 1'b0;
      r_addr  <= '0;
      r_v1    <= 1'b0;
      r_wrap1 <= 1'b0;
      r_v2    <= 1'b0;
      r_wrap2 <= 1'b0;
    end else begin
      if (ftw_load) r_ftw <= ftw_in;
      r_v1 <= w_issue;
      if (w_issue) begin
        r_addr  <= w_addr_phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
        r_acc   <= w_acc_sum[PHASE_WIDTH-1:0];
        // The carry of this add marks the next sample, whose phase is the wrapped result.
        r_wrap1 <= r_carry && !phase_clr;
        r_carry <= w_acc_sum[PHASE_WIDTH];
      end else if (phase_clr) begin
        r_acc   <= '0;
        r_carry <= 1'b0;
      end
      r_v2    <= r_v1;
      r_wrap2 <= r_wrap1;
    end
  end

  dds_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_v2),
    .i_data  ({r_wrap2, lut_q}),
    .i_pop   (sample_valid && sample_ready),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  assign sample       = w_head[DATA_WIDTH-1:0];
  assign sample_wrap  = w_head[DATA_WIDTH];
  assign sample_valid = !w_fifo_empty;
endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed and randomized bench for dds_phase_gen with a sine LUT model and a phase-arithmetic reference.
module tb_dds_phase_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        phase_clr;
  logic        ftw_load;
  logic [31:0] ftw_in;
  logic [31:0] phase_off;
  logic [7:0]  r_addr;
  logic [15:0] lut_q;
  logic [15:0] sample;
  logic        sample_wrap;
  logic        sample_valid;
  logic        sample_ready;

  logic [15:0] lut [256];
  logic [16:0] exp_q [$];
  logic [16:0] got_q [$];
  int          checks   = 0;
  int          failures = 0;
  int          consumed = 0;

  always #5 clk = ~clk;

  dds_phase_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .phase_clr    (phase_clr),
    .ftw_load     (ftw_load),
    .ftw_in       (ftw_in),
    .phase_off    (phase_off),
    .r_addr       (r_addr),
    .lut_q        (lut_q),
    .sample       (sample),
    .sample_wrap  (sample_wrap),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready)
  );

  // Registered-read sine RAM.
  always @(posedge clk) lut_q <= lut[r_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected stream: sample k reads lut at (k*ftw + off) top byte; wrap when k*ftw overflowed.
  task automatic gen_stream(input logic [31:0] ftw, input logic [31:0] off, input int n);
    logic [31:0] acc;
    logic [31:0] prev;
    logic [31:0] ph;
    logic        wrap;
    prev = '0;
    for (int k = 0; k < n; k++) begin
      acc  = 32'(64'(k) * 64'(ftw));
      wrap = (k > 0) && (acc < prev);
      ph   = acc + off;
      exp_q.push_back({wrap, lut[ph[31:24]]});
      prev = acc;
    end
  endtask

  task automatic tick();
    logic [16:0] e;
    if (sample_valid && sample_ready) begin
      got_q.push_back({sample_wrap, sample});
      consumed++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_underflow observed=%0h expected=none", {sample_wrap, sample});
      end else begin
        e = exp_q.pop_front();
        chk("sb_sample", {47'd0, sample_wrap, sample}, {47'd0, e});
      end
    end
    @(posedge clk);
    #1;
    phase_clr = 1'b0;
    ftw_load  = 1'b0;
  endtask

  task automatic run_until(input int target, input int budget, input bit rnd);
    int c;
    c = 0;
    while (consumed < target && c < budget) begin
      if (rnd) begin
        en           = ($urandom_range(0, 3) != 0);
        sample_ready = $urandom_range(0, 1);
      end
      tick();
      c++;
    end
    chk("run_within_budget", 64'(consumed >= target), 64'd1);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    en           = 1'b0;
    sample_ready = 1'b0;
    phase_clr    = 1'b0;
    ftw_load     = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", 64'(sample_valid), 64'd0);
    chk("rst_sample", 64'(sample), 64'd0);
    chk("rst_wrap", 64'(sample_wrap), 64'd0);
    chk("rst_addr", 64'(r_addr), 64'd0);
    rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    consumed = 0;
  endtask

  task automatic load_ftw(input logic [31:0] v);
    ftw_in   = v;
    ftw_load = 1'b1;
    tick();
  endtask

  initial begin
    real         v;
    int          iv;
    logic [31:0] rf;
    logic [7:0]  addr;
    for (int i = 0; i < 256; i++) begin
      v  = 32768.0 * $sin(2.0 * 3.14159265358979 * i / 256.0);
      iv = int'(v);
      if (iv > 32767)  iv = 32767;
      if (iv < -32767) iv = -32767;
      lut[i] = 16'(iv);
    end
    ftw_in    = '0;
    phase_off = '0;

    // 1: unit step, latency and first samples
    do_reset();
    load_ftw(32'h0100_0000);
    gen_stream(32'h0100_0000, 32'h0, 40);
    sample_ready = 1'b1;
    en = 1'b1;
    tick();
    chk("t1_addr0", 64'(r_addr), 64'h00);
    chk("t1_valid_e0", 64'(sample_valid), 64'd0);
    tick();
    chk("t1_addr1", 64'(r_addr), 64'h01);
    chk("t1_valid_e1", 64'(sample_valid), 64'd0);
    tick();
    chk("t1_addr2", 64'(r_addr), 64'h02);
    chk("t1_valid_e2", 64'(sample_valid), 64'd1);
    run_until(4, 50, 1'b0);
    chk("t1_s0", 64'(got_q[0]), 64'h00000);
    chk("t1_s1", 64'(got_q[1]), 64'h00324);
    chk("t1_s2", 64'(got_q[2]), 64'h00648);
    chk("t1_s3", 64'(got_q[3]), 64'h0096b);

    // 2: quarter-turn steps with a wrap on the fifth sample
    do_reset();
    load_ftw(32'h4000_0000);
    gen_stream(32'h4000_0000, 32'h0, 20);
    sample_ready = 1'b1;
    en = 1'b1;
    run_until(5, 50, 1'b0);
    chk("t2_s0", 64'(got_q[0]), 64'h00000);
    chk("t2_s1", 64'(got_q[1]), 64'h07fff);
    chk("t2_s2", 64'(got_q[2]), 64'h00000);
    chk("t2_s3", 64'(got_q[3]), 64'h08001);
    chk("t2_s4", 64'(got_q[4]), 64'h10000);

    // 3: backpressure fills the buffer and issue stops
    do_reset();
    load_ftw(32'h0100_0000);
    gen_stream(32'h0100_0000, 32'h0, 40);
    en = 1'b1;
    repeat (12) tick();
    chk("t3_addr_stalled", 64'(r_addr), 64'h03);
    chk("t3_valid", 64'(sample_valid), 64'd1);
    sample_ready = 1'b1;
    run_until(20, 100, 1'b0);

    // 4: static offset, then clear + reload while idle
    do_reset();
    phase_off = 32'h4000_0000;
    load_ftw(32'h0);
    gen_stream(32'h0, 32'h4000_0000, 30);
    en = 1'b1;
    sample_ready = 1'b1;
    run_until(6, 50, 1'b0);
    en = 1'b0;
    repeat (6) tick();
    chk("t4_drained", 64'(sample_valid), 64'd0);
    exp_q.delete();
    phase_clr = 1'b1;
    ftw_in    = 32'h0100_0000;
    ftw_load  = 1'b1;
    tick();
    consumed = 0;
    gen_stream(32'h0100_0000, 32'h4000_0000, 30);
    en = 1'b1;
    tick();
    chk("t4_addr_after_clr", 64'(r_addr), 64'h40);
    tick();
    chk("t4_addr_next", 64'(r_addr), 64'h41);
    run_until(10, 60, 1'b0);

    // 5: retune mid-stream, then clear while issuing
    do_reset();
    phase_off = 32'h0;
    load_ftw(32'h0100_0000);
    for (int k = 0; k < 60; k++) begin
      addr = (k <= 18) ? 8'(k) : 8'(18 + 2 * (k - 18));
      exp_q.push_back({1'b0, lut[addr]});
    end
    en = 1'b1;
    sample_ready = 1'b1;
    for (int c = 0; c < 100 && r_addr != 8'h10; c++) tick();
    chk("t5_reach_0x10", 64'(r_addr), 64'h10);
    ftw_in   = 32'h0200_0000;
    ftw_load = 1'b1;
    tick();
    chk("t5_addr_11", 64'(r_addr), 64'h11);
    tick();
    chk("t5_addr_12", 64'(r_addr), 64'h12);
    tick();
    chk("t5_addr_14", 64'(r_addr), 64'h14);
    tick();
    chk("t5_addr_16", 64'(r_addr), 64'h16);
    run_until(30, 60, 1'b0);
    en = 1'b0;
    repeat (6) tick();
    exp_q.delete();
    consumed = 0;
    gen_stream(32'h0200_0000, 32'h0, 30);
    phase_clr = 1'b1;
    en = 1'b1;
    tick();
    chk("t5_clr_issue_addr", 64'(r_addr), 64'h00);
    tick();
    chk("t5_clr_next_addr", 64'(r_addr), 64'h02);
    run_until(10, 60, 1'b0);

    // 6: reset with samples buffered
    do_reset();
    load_ftw(32'h0100_0000);
    gen_stream(32'h0100_0000, 32'h0, 40);
    en = 1'b1;
    repeat (5) tick();
    chk("t6_buffered", 64'(sample_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(sample_valid), 64'd0);
    chk("t6_rst_addr", 64'(r_addr), 64'h00);
    chk("t6_rst_sample", 64'(sample), 64'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b0;
    exp_q.delete();
    got_q.delete();
    consumed = 0;
    tick();
    chk("t6_no_glitch", 64'(sample_valid), 64'd0);
    load_ftw(32'h0100_0000);
    gen_stream(32'h0100_0000, 32'h0, 40);
    en = 1'b1;
    sample_ready = 1'b1;
    run_until(5, 50, 1'b0);
    chk("t6_restart_s0", 64'(got_q[0]), 64'h00000);

    // Randomized tuning words, offsets, enable and backpressure
    for (int s = 0; s < 6; s++) begin
      do_reset();
      phase_off = $urandom;
      rf = (s == 0) ? 32'hff00_0000 : 32'($urandom);
      load_ftw(rf);
      gen_stream(rf, phase_off, 80);
      run_until(40, 1500, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
